// File: rtl/instruction_pkg.sv
// Shared RV32I-subset encodings, sequencer state and ALU operation types.
// Also holds the immediate extractors and the legality check used by the sequencer.
package instruction_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} seq_state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASS_B
  } alu_op_t;

  function automatic logic [31:0] i_imm(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic is_legal(input logic [31:0] ir);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = ir[31:25];
    f3 = ir[14:12];
    case (ir[6:0])
      OPC_OP:     return (f7 == F7_BASE && (f3 == F3_ADD_SUB || f3 == F3_SLL || f3 == F3_SRL_SRA))
                      || (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA));
      OPC_OPIMM:  return (f3 == F3_ADD_SUB)
                      || (f3 == F3_SLL && f7 == F7_BASE)
                      || (f3 == F3_SRL_SRA && (f7 == F7_BASE || f7 == F7_ALT));
      OPC_BRANCH: return (f3 == F3_BEQ || f3 == F3_BNE);
      OPC_LUI:    return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational ALU for the sequencer: add/sub, logical/arithmetic shifts, pass-through.
module rv_alu
  import instruction_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    y = a + b;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << b[4:0];
      ALU_SRL:    y = a >> b[4:0];
      ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
      ALU_PASS_B: y = b;
      default:    y = a + b;
    endcase
  end

endmodule

// File: rtl/rv_core_seq.sv
// Multi-cycle RV32I-subset sequencer: FETCH/DECODE/EXEC/WB over a req/ack fetch port,
// with an external register file and a per-retire trace bus.
module rv_core_seq
  import instruction_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        tr_valid,
  output logic [31:0] tr_pc,
  output logic [31:0] tr_inst,
  output logic        tr_rdv,
  output logic [4:0]  tr_rd_x,
  output logic [31:0] tr_rd_data,
  output logic        tr_pcv,
  output logic [31:0] tr_pc_x,
  output logic        halted,
  output logic        illegal
);

  seq_state_t  state_q, state_d;
  logic [31:0] pc_q, ir_q, rs1_q, rs2_q, res_q, target_q;
  logic        taken_q, ill_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        writes_rd;
  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_y;
  logic        br_taken, misaligned;
  logic [31:0] br_target;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign rd        = ir_q[11:7];
  assign rs1_addr  = ir_q[19:15];
  assign rs2_addr  = ir_q[24:20];
  assign writes_rd = (opcode == OPC_OP) || (opcode == OPC_OPIMM) || (opcode == OPC_LUI);

  // ir_q[30] separates sub/sra/srai from add/srl/srli; legality was already checked in DECODE.
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = rs2_q;
    case (opcode)
      OPC_OP: begin
        case (funct3)
          F3_SLL:     alu_op = ALU_SLL;
          F3_SRL_SRA: alu_op = ir_q[30] ? ALU_SRA : ALU_SRL;
          default:    alu_op = ir_q[30] ? ALU_SUB : ALU_ADD;
        endcase
      end
      OPC_OPIMM: begin
        alu_b = i_imm(ir_q);
        case (funct3)
          F3_SLL:     alu_op = ALU_SLL;
          F3_SRL_SRA: alu_op = ir_q[30] ? ALU_SRA : ALU_SRL;
          default:    alu_op = ALU_ADD;
        endcase
      end
      OPC_LUI: begin
        alu_op = ALU_PASS_B;
        alu_b  = {ir_q[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  rv_alu u_alu (
    .op (alu_op),
    .a  (rs1_q),
    .b  (alu_b),
    .y  (alu_y)
  );

  assign br_target  = pc_q + b_imm(ir_q);
  assign br_taken   = (opcode == OPC_BRANCH) &&
                      ((funct3 == F3_BEQ) ? (rs1_q == rs2_q) : (rs1_q != rs2_q));
  assign misaligned = br_taken && br_target[1];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      res_q    <= '0;
      target_q <= '0;
      taken_q  <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FETCH:  if (imem_ack) ir_q <= imem_rdata;
        DECODE: begin
          rs1_q   <= rs1_data;
          rs2_q   <= rs2_data;
          ill_q   <= !is_legal(ir_q);
          taken_q <= 1'b0;
        end
        EXEC: begin
          res_q    <= alu_y;
          target_q <= br_target;
          taken_q  <= br_taken && !misaligned;
          if (misaligned) ill_q <= 1'b1;
        end
        WB:      if (!ill_q) pc_q <= taken_q ? target_q : pc_q + 32'd4;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (imem_ack) state_d = DECODE;
      // An illegal word skips EXEC and retires straight away with no side effects.
      DECODE:  state_d = is_legal(ir_q) ? EXEC : WB;
      EXEC:    state_d = WB;
      WB:      state_d = (ill_q || halt_req) ? HALT : FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    tr_valid   = 1'b0;
    tr_pc      = '0;
    tr_inst    = '0;
    tr_rdv     = 1'b0;
    tr_rd_x    = '0;
    tr_rd_data = '0;
    tr_pcv     = 1'b0;
    tr_pc_x    = '0;
    halted     = (state_q == HALT);
    illegal    = (state_q == HALT) && ill_q;
    case (state_q)
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
      end
      WB: begin
        tr_valid   = 1'b1;
        tr_pc      = pc_q;
        tr_inst    = ir_q;
        rf_we      = writes_rd && (rd != 5'd0) && !ill_q;
        tr_rdv     = rf_we;
        rf_waddr   = rd;
        tr_rd_x    = rd;
        rf_wdata   = res_q;
        tr_rd_data = res_q;
        tr_pcv     = taken_q;
        tr_pc_x    = taken_q ? target_q : 32'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv_core_seq.sv
// Self-checking bench for rv_core_seq: instruction-level reference model with an
// instruction encoder, directed corner cases and randomized instruction streams.
module tb_rv_core_seq;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt_req = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rf_we, tr_valid, tr_rdv, tr_pcv, halted, illegal;
  logic [4:0]  rf_waddr, tr_rd_x;
  logic [31:0] rf_wdata, tr_pc, tr_inst, tr_rd_data, tr_pc_x;

  rv_core_seq #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .tr_valid(tr_valid), .tr_pc(tr_pc), .tr_inst(tr_inst), .tr_rdv(tr_rdv),
    .tr_rd_x(tr_rd_x), .tr_rd_data(tr_rd_data), .tr_pcv(tr_pcv), .tr_pc_x(tr_pc_x),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Architectural state of the reference model; also serves as the register file.
  logic [31:0] rf [32];
  logic [31:0] m_pc;
  int n_checks = 0;
  int n_fail   = 0;

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  typedef enum int {M_ADD, M_SUB, M_SLL, M_SRL, M_SRA, M_ADDI, M_SLLI, M_SRLI, M_SRAI,
                    M_BEQ, M_BNE, M_LUI} mn_t;

  typedef struct {
    mn_t         mn;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    bit          raw;
    logic [31:0] word;
  } instr_t;

  typedef struct packed {
    logic        ill;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        taken;
    logic [31:0] target;
    logic [3:0]  lat;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic instr_t mk(mn_t mn, int rd, int rs1, int rs2, logic [31:0] imm);
    instr_t s;
    s.mn = mn; s.rd = 5'(rd); s.rs1 = 5'(rs1); s.rs2 = 5'(rs2);
    s.imm = imm; s.raw = 1'b0; s.word = '0;
    return s;
  endfunction

  function automatic instr_t mk_raw(logic [31:0] w);
    instr_t s;
    s = mk(M_ADD, 0, 0, 0, 0);
    s.raw = 1'b1; s.word = w;
    return s;
  endfunction

  function automatic logic [31:0] encode(instr_t s);
    case (s.mn)
      M_ADD:  return {7'h00, s.rs2, s.rs1, 3'b000, s.rd, 7'h33};
      M_SUB:  return {7'h20, s.rs2, s.rs1, 3'b000, s.rd, 7'h33};
      M_SLL:  return {7'h00, s.rs2, s.rs1, 3'b001, s.rd, 7'h33};
      M_SRL:  return {7'h00, s.rs2, s.rs1, 3'b101, s.rd, 7'h33};
      M_SRA:  return {7'h20, s.rs2, s.rs1, 3'b101, s.rd, 7'h33};
      M_ADDI: return {s.imm[11:0], s.rs1, 3'b000, s.rd, 7'h13};
      M_SLLI: return {7'h00, s.imm[4:0], s.rs1, 3'b001, s.rd, 7'h13};
      M_SRLI: return {7'h00, s.imm[4:0], s.rs1, 3'b101, s.rd, 7'h13};
      M_SRAI: return {7'h20, s.imm[4:0], s.rs1, 3'b101, s.rd, 7'h13};
      M_BEQ:  return {s.imm[12], s.imm[10:5], s.rs2, s.rs1, 3'b000, s.imm[4:1], s.imm[11], 7'h63};
      M_BNE:  return {s.imm[12], s.imm[10:5], s.rs2, s.rs1, 3'b001, s.imm[4:1], s.imm[11], 7'h63};
      M_LUI:  return {s.imm[31:12], s.rd, 7'h37};
      default: return 32'h0;
    endcase
  endfunction

  function automatic exp_t predict(instr_t s, logic [31:0] pc);
    exp_t e;
    logic [31:0] a, b;
    logic wr, tk;
    e = '0;
    a = rf[s.rs1];
    b = rf[s.rs2];
    wr = 1'b1;
    tk = 1'b0;
    e.lat = s.raw ? 4'd2 : 4'd3;
    if (s.raw) begin
      e.ill = 1'b1;
      return e;
    end
    e.rd = s.rd;
    case (s.mn)
      M_ADD:  e.val = a + b;
      M_SUB:  e.val = a - b;
      M_SLL:  e.val = a << b[4:0];
      M_SRL:  e.val = a >> b[4:0];
      M_SRA:  e.val = $unsigned($signed(a) >>> b[4:0]);
      M_ADDI: e.val = a + s.imm;
      M_SLLI: e.val = a << s.imm[4:0];
      M_SRLI: e.val = a >> s.imm[4:0];
      M_SRAI: e.val = $unsigned($signed(a) >>> s.imm[4:0]);
      M_LUI:  e.val = s.imm & 32'hFFFF_F000;
      default: begin
        wr = 1'b0;
        tk = (s.mn == M_BEQ) ? (a == b) : (a != b);
        e.target = pc + s.imm;
        if (tk && e.target[1]) e.ill = 1'b1;
        else e.taken = tk;
      end
    endcase
    e.we = wr && (s.rd != 5'd0);
    return e;
  endfunction

  function automatic instr_t rand_instr();
    instr_t s;
    logic [31:0] r;
    s = mk(mn_t'($urandom_range(0, 11)), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), 0);
    r = $urandom;
    case (s.mn)
      M_ADDI: s.imm = {{20{r[11]}}, r[11:0]};
      M_SLLI, M_SRLI, M_SRAI: s.imm = {27'd0, r[4:0]};
      M_LUI: s.imm = r & 32'hFFFF_F000;
      M_BEQ, M_BNE: begin
        if (r[31]) s.rs2 = s.rs1;
        s.imm = 32'($urandom_range(0, 1023)) * 32'd4 - 32'd2048;
      end
      default: s.imm = 32'd0;
    endcase
    return s;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    halt_req = 1'b0;
    imem_ack = 1'b0;
    #1;
    check("reset_imem_req", imem_req, 0);
    check("reset_outputs_zero",
          {31'd0, |{imem_req, imem_addr, rs1_addr, rs2_addr, rf_we, rf_waddr, rf_wdata,
                    tr_valid, tr_pc, tr_inst, tr_rdv, tr_rd_x, tr_rd_data, tr_pcv, tr_pc_x,
                    halted, illegal}}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("idle_no_req", imem_req, 0);
    m_pc = RESET_PC;
    @(negedge clk);
  endtask

  // Runs one instruction starting at a FETCH-state negedge; returns at the next boundary.
  task automatic step(input instr_t s, input int waits, input bit hreq);
    logic [31:0] w;
    exp_t e;
    int lat;
    bit got;
    w = s.raw ? s.word : encode(s);
    e = predict(s, m_pc);
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, m_pc);
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      check("wait_req_held", imem_req, 1);
      check("wait_addr_stable", imem_addr, m_pc);
      check("wait_no_retire", tr_valid, 0);
    end
    imem_ack = 1'b1;
    imem_rdata = w;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        imem_rdata = $urandom;
        if (!s.raw && s.mn inside {M_ADD, M_SUB, M_SLL, M_SRL, M_SRA, M_BEQ, M_BNE}) begin
          check("decode_rs1_addr", rs1_addr, s.rs1);
          check("decode_rs2_addr", rs2_addr, s.rs2);
        end
      end
      if (lat == 2 && hreq) halt_req = 1'b1;
      if (tr_valid) got = 1'b1;
    end
    imem_ack = 1'b0;
    check("retire_seen", got, 1);
    if (got) begin
      check("retire_latency", lat, e.lat);
      check("tr_pc", tr_pc, m_pc);
      check("tr_inst", tr_inst, w);
      check("rf_we", rf_we, e.we);
      check("tr_rdv", tr_rdv, e.we);
      if (e.we) begin
        check("rf_waddr", rf_waddr, e.rd);
        check("tr_rd_x", tr_rd_x, e.rd);
        check("rf_wdata", rf_wdata, e.val);
        check("tr_rd_data", tr_rd_data, e.val);
      end
      check("tr_pcv", tr_pcv, e.taken);
      if (e.taken) check("tr_pc_x", tr_pc_x, e.target);
      check("not_halted_in_wb", halted, 0);
    end
    if (e.we) rf[e.rd] = e.val;
    if (!e.ill) m_pc = e.taken ? e.target : m_pc + 32'd4;
    @(negedge clk);
    halt_req = 1'b0;
    check("pulse_cleared", tr_valid, 0);
    if (e.ill || hreq) begin
      for (int i = 0; i < 3; i++) begin
        check("halted", halted, 1);
        check("illegal_flag", illegal, e.ill);
        check("halt_no_req", imem_req, 0);
        @(negedge clk);
      end
    end else begin
      check("still_running", halted, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    m_pc = RESET_PC;
    @(negedge clk);
    apply_reset();

    step(mk(M_ADDI, 1, 0, 0, 5), 0, 0);
    step(mk(M_ADDI, 2, 0, 0, 7), 3, 0);
    step(mk(M_BEQ, 0, 1, 1, 8), 0, 0);
    step(mk(M_BNE, 0, 1, 1, 8), 1, 0);
    step(mk(M_SUB, 3, 1, 2, 0), 0, 0);
    step(mk(M_LUI, 1, 0, 0, 32'h8000_0000), 0, 0);
    step(mk(M_SRAI, 4, 1, 0, 4), 2, 0);
    step(mk(M_ADDI, 0, 0, 0, 0), 0, 0);
    step(mk(M_SRA, 5, 1, 3, 0), 0, 0);
    step(mk(M_SRL, 6, 1, 3, 0), 0, 0);

    for (int i = 5; i < 8; i++) rf[i] = $urandom;
    for (int n = 0; n < 60; n++) step(rand_instr(), $urandom_range(0, 2), 0);

    step(mk(M_ADDI, 6, 6, 0, 1), 0, 1);
    apply_reset();

    step(mk(M_ADDI, 1, 1, 0, 3), 0, 0);
    imem_ack = 1'b0;
    @(negedge clk);
    check("pre_reset_fetch_req", imem_req, 1);
    apply_reset();
    step(mk(M_ADD, 2, 1, 1, 0), 1, 0);

    step(mk_raw(32'h0000_0000), 0, 0);
    apply_reset();
    step(mk_raw(32'h0220_8033), 1, 0);
    apply_reset();
    step(mk(M_BEQ, 0, 0, 0, 6), 0, 0);
    apply_reset();
    step(mk(M_SLL, 7, 1, 2, 0), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
